// File: rtl/dma_request_scheduler_if.sv
// Signal bundle between the DMA request scheduler and its surroundings:
// timer channel 1, peripheral DREQ lines and the 8237 DREQ/DACK/TC pins.
interface dma_request_scheduler_if #(
  parameter int REFRESH_DEPTH = 4
) ();
  localparam int W = $clog2(REFRESH_DEPTH + 1);

  logic         i_cpu_clock;
  logic         i_refresh_timer_out;
  logic [2:0]   i_peripheral_drq;
  logic [3:0]   i_channel_enable;
  logic [3:0]   i_dma_acknowledge_n;
  logic         i_terminal_count_n;
  logic         i_status_clear;
  logic [3:0]   o_dma_request;
  logic [W-1:0] o_refresh_pending;
  logic         o_refresh_overrun;
  logic [3:0]   o_timeout_status;

  modport slave (
    input  i_cpu_clock, i_refresh_timer_out, i_peripheral_drq, i_channel_enable,
           i_dma_acknowledge_n, i_terminal_count_n, i_status_clear,
    output o_dma_request, o_refresh_pending, o_refresh_overrun, o_timeout_status
  );

  modport master (
    output i_cpu_clock, i_refresh_timer_out, i_peripheral_drq, i_channel_enable,
           i_dma_acknowledge_n, i_terminal_count_n, i_status_clear,
    input  o_dma_request, o_refresh_pending, o_refresh_overrun, o_timeout_status
  );
endinterface

// File: rtl/dma_request_scheduler.sv
// Conditions the four DREQ lines into the 8237: DRAM refresh requests on channel 0,
// synchronised/masked peripheral requests on channels 1-3, with hold, TC block and timeout.
module dma_request_scheduler #(
  parameter int SYNC_STAGES   = 2,
  parameter int REFRESH_DEPTH = 4,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  dma_request_scheduler_if.slave  bus
);
  localparam int W  = $clog2(REFRESH_DEPTH + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [W-1:0]  PEND_MAX     = W'(REFRESH_DEPTH);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, ACK, BLOCK, BACKOFF} state_t;

  logic [SYNC_STAGES-1:0][2:0] r_drqSync;
  logic [SYNC_STAGES-1:0]      r_timerSync;
  logic                        r_timerPrev;
  logic                        r_prevCpuClock;
  logic [W-1:0]                r_pending;
  logic                        r_overrun;
  logic [3:0]                  r_timeoutStatus;
  logic [3:0]                  r_dmaRequest;
  state_t                      r_state [4];
  logic [TW-1:0]               r_timeout [4];

  state_t                      w_stateNext [4];
  logic [TW-1:0]               w_timeoutNext [4];
  logic [2:0]                  w_drqSynced;
  logic                        w_timerRise;
  logic                        w_cpuEdge;
  logic                        w_grant0;
  logic [3:0]                  w_want;
  logic [3:0]                  w_reqDrop;
  logic [3:0]                  w_blockDone;
  logic [3:0]                  w_timeoutSet;

  assign w_drqSynced = r_drqSync[SYNC_STAGES-1];
  assign w_timerRise = r_timerSync[SYNC_STAGES-1] & ~r_timerPrev;
  assign w_cpuEdge   = ~r_prevCpuClock & bus.i_cpu_clock;

  // Channel 0 wants service while refreshes are owed; it never drops on a DRQ because it has none.
  assign w_want      = {w_drqSynced, (r_pending != '0)};
  assign w_reqDrop   = ~bus.i_channel_enable | {~w_drqSynced, 1'b0};
  assign w_blockDone = bus.i_dma_acknowledge_n & {~w_drqSynced, 1'b1};
  assign w_grant0    = w_cpuEdge & (r_state[0] == REQ) & ~bus.i_dma_acknowledge_n[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_drqSync      <= '0;
      r_timerSync    <= '0;
      r_timerPrev    <= 1'b0;
      r_prevCpuClock <= 1'b0;
    end else begin
      r_drqSync      <= {r_drqSync[SYNC_STAGES-2:0], bus.i_peripheral_drq};
      r_timerSync    <= {r_timerSync[SYNC_STAGES-2:0], bus.i_refresh_timer_out};
      r_timerPrev    <= r_timerSync[SYNC_STAGES-1];
      r_prevCpuClock <= bus.i_cpu_clock;
    end
  end

  // A refresh edge and a channel-0 grant in the same clock cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else if (w_timerRise && !w_grant0) begin
      if (r_pending != PEND_MAX) begin
        r_pending <= r_pending + W'(1);
      end
    end else if (!w_timerRise && w_grant0 && (r_pending != '0)) begin
      r_pending <= r_pending - W'(1);
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_stateNext[n]   = r_state[n];
      w_timeoutNext[n] = r_timeout[n];
      w_timeoutSet[n]  = 1'b0;
      if (w_cpuEdge) begin
        case (r_state[n])
          IDLE: begin
            if (bus.i_channel_enable[n] && w_want[n]) begin
              w_stateNext[n] = REQ;
            end
          end
          REQ: begin
            if (!bus.i_dma_acknowledge_n[n]) begin
              w_stateNext[n]   = ACK;
              w_timeoutNext[n] = '0;
            end else if (w_reqDrop[n]) begin
              w_stateNext[n]   = IDLE;
              w_timeoutNext[n] = '0;
            end else if (r_timeout[n] == TIMEOUT_LAST) begin
              w_stateNext[n]   = BACKOFF;
              w_timeoutNext[n] = '0;
              w_timeoutSet[n]  = 1'b1;
            end else begin
              w_timeoutNext[n] = r_timeout[n] + TW'(1);
            end
          end
          ACK: begin
            if (!bus.i_dma_acknowledge_n[n] && !bus.i_terminal_count_n) begin
              w_stateNext[n] = BLOCK;
            end else if (bus.i_dma_acknowledge_n[n]) begin
              w_stateNext[n] = IDLE;
            end
          end
          BLOCK: begin
            if (w_blockDone[n]) begin
              w_stateNext[n] = IDLE;
            end
          end
          BACKOFF: w_stateNext[n] = IDLE;
          default: w_stateNext[n] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        r_state[n]   <= IDLE;
        r_timeout[n] <= '0;
      end
      r_dmaRequest <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        r_state[n]   <= w_stateNext[n];
        r_timeout[n] <= w_timeoutNext[n];
        if (w_cpuEdge) begin
          r_dmaRequest[n] <= (w_stateNext[n] == REQ);
        end
      end
    end
  end

  // A set arriving in the same clock as status_clear wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overrun       <= 1'b0;
      r_timeoutStatus <= '0;
    end else begin
      if (w_timerRise && (r_pending == PEND_MAX)) begin
        r_overrun <= 1'b1;
      end else if (bus.i_status_clear) begin
        r_overrun <= 1'b0;
      end
      r_timeoutStatus <= (bus.i_status_clear ? 4'b0000 : r_timeoutStatus) | w_timeoutSet;
    end
  end

  assign bus.o_dma_request     = r_dmaRequest;
  assign bus.o_refresh_pending = r_pending;
  assign bus.o_refresh_overrun = r_overrun;
  assign bus.o_timeout_status  = r_timeoutStatus;
endmodule
